// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready byte handshake and error strobes.
// Build option: define UART_RX_BREAK_DETECT_EN to report all-zero frames with a low stop bit as break_strobe.

module uart_rx #(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       break_strobe
);

   // state     | meaning
   // IDLE      | line idle, waiting for a low level
   // START     | qualifying the start bit at its midpoint
   // DATA      | sampling 8 data bits, LSB first
   // STOP      | sampling the stop bit
   // WAIT_HIGH | bad stop bit, waiting for the line to return high
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

   logic [1:0]    rxd_sync;
   logic          rxd_s;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic          stop_tc;
   logic          deliver;
   logic          stop_bad;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rxd_sync <= 2'b11;
      end else begin
         rxd_sync <= {rxd_sync[0], rxd};
      end
   end

   assign rxd_s    = rxd_sync[1];
   assign stop_tc  = (state == S_STOP) && (cnt == CNT_LAST);
   assign deliver  = stop_tc && rxd_s;
   assign stop_bad = stop_tc && !rxd_s;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!rxd_s) begin
                  state <= S_START;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  idx <= '0;
                  state <= rxd_s ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  shift[idx] <= rxd_s;
                  if (idx == 3'd7) begin
                     state <= S_STOP;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= rxd_s ? S_IDLE : S_WAIT_HIGH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WAIT_HIGH: begin
               cnt <= '0;
               if (rxd_s) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Output holding register; an unconsumed byte wins over a newly arrived one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (deliver) begin
            if (rx_valid && !rx_ready) begin
               overrun <= 1'b1;
            end else begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         break_strobe <= 1'b0;
`endif
      end else begin
`ifdef UART_RX_BREAK_DETECT_EN
         frame_err    <= stop_bad && (shift != 8'h00);
         break_strobe <= stop_bad && (shift == 8'h00);
`else
         frame_err <= stop_bad;
`endif
      end
   end

`ifndef UART_RX_BREAK_DETECT_EN
   assign break_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table vectors, directed corner sequences and random frames against a frame-level model.
// Expects break_strobe instead of frame_err when UART_RX_BREAK_DETECT_EN is defined.

module tb_uart_rx;

   localparam int BD = 16;
`ifdef UART_RX_BREAK_DETECT_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   logic       clk;
   logic       resetn;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       break_strobe;

   uart_rx #(.BAUD_DIV(BD)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .rxd          (rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .frame_err    (frame_err),
      .overrun      (overrun),
      .break_strobe (break_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   int n_valid = 0;
   int n_ferr  = 0;
   int n_ovr   = 0;
   int n_brk   = 0;
   logic [7:0] xfer_q[$];

   logic       prev_valid = 1'b0;
   logic       prev_xfer  = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Event monitor: counts strobe cycles and valid rises, records transfers.
   always @(negedge clk) begin
      if (rx_valid && !prev_valid) n_valid++;
      if (frame_err)    n_ferr++;
      if (overrun)      n_ovr++;
      if (break_strobe) n_brk++;
      if (frame_err || overrun || break_strobe)
         chk("strobe_exclusive", int'(frame_err) + int'(overrun) + int'(break_strobe), 1);
      if (rx_valid && prev_valid && !prev_xfer)
         chk("rx_data_stable", rx_data, prev_data);
      if (rx_valid && rx_ready) xfer_q.push_back(rx_data);
      prev_valid = rx_valid;
      prev_xfer  = rx_valid && rx_ready;
      prev_data  = rx_data;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic stop);
      rxd = 1'b0;
      wait_cyc(BD);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         wait_cyc(BD);
      end
      rxd = stop;
      wait_cyc(BD);
      rxd = 1'b1;
      wait_cyc(BD);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_valid;
      int         exp_ferr;
      int         exp_brk;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int v0, f0, o0, b0, lat, xb;
      logic [7:0] exp_q[$];
      int exp_ferr_r, exp_brk_r;

      vecs[0] = '{8'h00, 1'b1, 1, 0, 0};
      vecs[1] = '{8'hFF, 1'b1, 1, 0, 0};
      vecs[2] = '{8'h80, 1'b1, 1, 0, 0};
      vecs[3] = '{8'h01, 1'b1, 1, 0, 0};
      vecs[4] = '{8'h55, 1'b0, 0, 1, 0};
      vecs[5] = '{8'h00, 1'b0, 0, BRK_EN ? 0 : 1, BRK_EN ? 1 : 0};
      vecs[6] = '{8'hC9, 1'b1, 1, 0, 0};

      rxd      = 1'b1;
      rx_ready = 1'b1;
      resetn   = 1'b0;
      wait_cyc(3);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_strobes", int'(frame_err) + int'(overrun) + int'(break_strobe), 0);
      resetn = 1'b1;
      wait_cyc(4);

      // Exact delivery latency for 0xA5
      lat = 0;
      fork
         drive_frame(8'hA5, 1'b1);
         begin
            while (!rx_valid && lat < 400) begin
               @(posedge clk);
               #1;
               lat++;
            end
            chk("a5_latency", lat, 155);
            chk("a5_data", rx_data, 8'hA5);
            wait_cyc(1);
            chk("a5_one_cycle", rx_valid, 0);
         end
      join

      // Short glitch is rejected, next frame is fine
      v0 = n_valid; f0 = n_ferr; o0 = n_ovr; b0 = n_brk;
      rxd = 1'b0;
      wait_cyc(6);
      rxd = 1'b1;
      wait_cyc(3 * BD);
      chk("glitch_no_valid", n_valid - v0, 0);
      chk("glitch_no_strobe", (n_ferr - f0) + (n_ovr - o0) + (n_brk - b0), 0);
      drive_frame(8'h3C, 1'b1);
      chk("post_glitch_valid", n_valid - v0, 1);
      chk("post_glitch_data", xfer_q[$], 8'h3C);

      // Table of single frames with rx_ready held high
      for (int i = 0; i < 7; i++) begin
         v0 = n_valid; f0 = n_ferr; b0 = n_brk;
         drive_frame(vecs[i].data, vecs[i].stop);
         wait_cyc(BD);
         chk($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
         chk($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
         chk($sformatf("vec%0d_brk", i), n_brk - b0, vecs[i].exp_brk);
         if (vecs[i].exp_valid == 1) chk($sformatf("vec%0d_data", i), xfer_q[$], vecs[i].data);
      end

      // Overrun: second byte dropped while the first is pending
      o0 = n_ovr;
      rx_ready = 1'b0;
      drive_frame(8'h11, 1'b1);
      drive_frame(8'h22, 1'b1);
      chk("ovr_valid_held", rx_valid, 1);
      chk("ovr_data_kept", rx_data, 8'h11);
      chk("ovr_pulse_once", n_ovr - o0, 1);
      rx_ready = 1'b1;
      wait_cyc(1);
      chk("ovr_valid_fell", rx_valid, 0);
      chk("ovr_xfer_data", xfer_q[$], 8'h11);

      // Delivery coinciding with a transfer replaces the byte without overrun
      rx_ready = 1'b0;
      drive_frame(8'h44, 1'b1);
      o0 = n_ovr;
      fork
         drive_frame(8'h55, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1;
            rx_ready = 1'b1;
            wait_cyc(1);
            chk("coin_valid", rx_valid, 1);
            chk("coin_data", rx_data, 8'h55);
         end
      join
      chk("coin_no_ovr", n_ovr - o0, 0);
      chk("coin_xfer_last", xfer_q[$], 8'h55);

      // Bad stop bit then line held low for 40 bit times
      v0 = n_valid; f0 = n_ferr; b0 = n_brk;
      rxd = 1'b0;
      wait_cyc(BD);
      for (int i = 0; i < 8; i++) begin
         rxd = (8'h7E >> i) & 1;
         wait_cyc(BD);
      end
      rxd = 1'b0;
      wait_cyc(41 * BD);
      chk("ferr_once_low", n_ferr - f0, 1);
      chk("ferr_no_valid_low", n_valid - v0, 0);
      rxd = 1'b1;
      wait_cyc(3 * BD);
      chk("ferr_once_after", n_ferr - f0, 1);
      chk("ferr_no_brk", n_brk - b0, 0);
      chk("ferr_no_valid_after", n_valid - v0, 0);

      // Line held low for 12 bit times
      f0 = n_ferr; b0 = n_brk;
      rxd = 1'b0;
      wait_cyc(12 * BD);
      rxd = 1'b1;
      wait_cyc(3 * BD);
      chk("break_brk", n_brk - b0, BRK_EN ? 1 : 0);
      chk("break_ferr", n_ferr - f0, BRK_EN ? 0 : 1);

      // Reset in the middle of 0xC3 with a byte pending
      rx_ready = 1'b0;
      drive_frame(8'h99, 1'b1);
      rxd = 1'b0;
      wait_cyc(BD);
      for (int i = 0; i < 5; i++) begin
         rxd = (8'hC3 >> i) & 1;
         wait_cyc(BD);
      end
      wait_cyc(BD / 2);
      resetn = 1'b0;
      rxd = 1'b1;
      #1;
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_break", break_strobe, 0);
      wait_cyc(3);
      resetn = 1'b1;
      rx_ready = 1'b1;
      v0 = n_valid; f0 = n_ferr; o0 = n_ovr; b0 = n_brk;
      wait_cyc(4 * BD);
      chk("rst_abort_quiet", (n_valid - v0) + (n_ferr - f0) + (n_ovr - o0) + (n_brk - b0), 0);
      drive_frame(8'h5A, 1'b1);
      chk("rst_next_valid", n_valid - v0, 1);
      chk("rst_next_data", xfer_q[$], 8'h5A);

      // Random frames against a frame-level model
      xb = xfer_q.size();
      f0 = n_ferr; b0 = n_brk;
      exp_ferr_r = 0; exp_brk_r = 0;
      for (int k = 0; k < 40; k++) begin
         logic [7:0] d;
         logic       s;
         d = 8'($urandom_range(0, 255));
         if (k % 13 == 5) d = 8'h00;
         s = ($urandom_range(0, 6) != 0);
         drive_frame(d, s);
         wait_cyc($urandom_range(0, 20));
         if (s) exp_q.push_back(d);
         else if (d == 8'h00 && BRK_EN) exp_brk_r++;
         else exp_ferr_r++;
      end
      wait_cyc(BD);
      chk("rand_xfer_count", xfer_q.size() - xb, exp_q.size());
      for (int k = 0; k < exp_q.size() && (xb + k) < xfer_q.size(); k++)
         chk($sformatf("rand_byte%0d", k), xfer_q[xb + k], exp_q[k]);
      chk("rand_ferr", n_ferr - f0, exp_ferr_r);
      chk("rand_brk", n_brk - b0, exp_brk_r);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
